// File: rtl/hash_io_ctrl.sv
// Host-side word I/O controller for a wide hash core: packs IO_W words into BLK_W blocks
// and serialises the DIG_W digest back out. Optional cycle counter: HASH_IO_CYCLE_CNT_EN.
module hash_io_ctrl #(
  parameter int IO_W  = 16,
  parameter int BLK_W = 512,
  parameter int DIG_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             load_i,
  input  logic             fetch_i,
  input  logic [IO_W-1:0]  idata_i,
  output logic             ack_o,
  output logic [IO_W-1:0]  odata_o,
  output logic             err_o,
  output logic             core_init_o,
  output logic             core_start_o,
  output logic [BLK_W-1:0] core_blk_o,
  input  logic             core_done_i,
  input  logic [DIG_W-1:0] core_dig_i
`ifdef HASH_IO_CYCLE_CNT_EN
  ,
  output logic [31:0]      cycle_cnt_o
`endif
);

  localparam int NB  = BLK_W / IO_W;
  localparam int ND  = DIG_W / IO_W;
  localparam int WCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int FCW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HASH, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [BLK_W-1:0] buf_q, buf_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [IO_W-1:0]  odata_q, odata_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             cinit_q, cinit_d;
  logic             cstart_q, cstart_d;
  logic             hashed_q, hashed_d;

  logic [BLK_W-1:0] shifted;
  logic             emit;

  assign shifted = (buf_q << IO_W) | BLK_W'(idata_i);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    fcnt_d   = fcnt_q;
    buf_d    = buf_q;
    blk_d    = blk_q;
    dig_d    = dig_q;
    odata_d  = odata_q;
    err_d    = err_q;
    hashed_d = hashed_q;
    ack_d    = 1'b0;
    cinit_d  = 1'b0;
    cstart_d = 1'b0;
    emit     = 1'b0;

    if (init_i) begin
      state_d  = S_LOAD;
      wcnt_d   = '0;
      fcnt_d   = '0;
      buf_d    = '0;
      dig_d    = '0;
      err_d    = 1'b0;
      hashed_d = 1'b0;
      cinit_d  = 1'b1;
      ack_d    = 1'b1;
    end else if (load_i && fetch_i) begin
      err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_i || fetch_i) err_d = 1'b1;
        end
        S_LOAD: begin
          if (load_i) begin
            buf_d = shifted;
            ack_d = 1'b1;
            if (wcnt_q == WCW'(NB - 1)) begin
              wcnt_d   = '0;
              blk_d    = shifted;
              cstart_d = 1'b1;
              state_d  = S_HASH;
            end else begin
              wcnt_d = wcnt_q + WCW'(1);
            end
          end else if (fetch_i) begin
            if (wcnt_q != '0 || !hashed_q) begin
              err_d = 1'b1;
            end else begin
              emit = 1'b1;
              if (ND == 1) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_OUT;
                fcnt_d  = FCW'(1);
              end
            end
          end
        end
        // load/fetch here are simply not acknowledged; the host keeps them asserted
        S_HASH: begin
          if (core_done_i) begin
            dig_d    = core_dig_i;
            hashed_d = 1'b1;
            state_d  = S_LOAD;
          end
        end
        S_OUT: begin
          if (load_i) begin
            err_d = 1'b1;
          end else if (fetch_i) begin
            emit = 1'b1;
            if (fcnt_q == FCW'(ND - 1)) begin
              state_d = S_IDLE;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_q + FCW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (emit) begin
      odata_d = dig_q[DIG_W-1 -: IO_W];
      dig_d   = dig_q << IO_W;
      ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      buf_q    <= '0;
      blk_q    <= '0;
      dig_q    <= '0;
      odata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      cinit_q  <= 1'b0;
      cstart_q <= 1'b0;
      hashed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      fcnt_q   <= fcnt_d;
      buf_q    <= buf_d;
      blk_q    <= blk_d;
      dig_q    <= dig_d;
      odata_q  <= odata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cinit_q  <= cinit_d;
      cstart_q <= cstart_d;
      hashed_q <= hashed_d;
    end
  end

  assign ack_o        = ack_q;
  assign odata_o      = odata_q;
  assign err_o        = err_q;
  assign core_init_o  = cinit_q;
  assign core_start_o = cstart_q;
  assign core_blk_o   = blk_q;

`ifdef HASH_IO_CYCLE_CNT_EN
  // Start/stop are taken from the registered ack so both ends shift by the same cycle.
  logic [31:0] ccnt_q, ccnt_d;
  logic        crun_q, crun_d;

  always_comb begin
    ccnt_d = ccnt_q;
    crun_d = crun_q;
    if (init_i) begin
      ccnt_d = '0;
      crun_d = 1'b0;
    end else begin
      if (crun_q && ccnt_q != 32'hFFFF_FFFF) ccnt_d = ccnt_q + 32'd1;
      if (ack_q && state_q == S_IDLE)
        crun_d = 1'b0;
      else if (ack_q && !cinit_q && (state_q == S_LOAD || state_q == S_HASH))
        crun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccnt_q <= '0;
      crun_q <= 1'b0;
    end else begin
      ccnt_q <= ccnt_d;
      crun_q <= crun_d;
    end
  end

  assign cycle_cnt_o = ccnt_q;
`endif

endmodule

// File: tb/tb_hash_io_ctrl.sv
// Self-checking bench for hash_io_ctrl (IO_W=16, BLK_W=64, DIG_W=32) with a simple core stub.
module tb_hash_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        init, load, fetch;
  logic [15:0] idata;
  logic        ack, err, core_init, core_start, core_done;
  logic [15:0] odata;
  logic [63:0] core_blk;
  logic [31:0] core_dig;
`ifdef HASH_IO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int t_first, t_last;

  hash_io_ctrl #(.IO_W(16), .BLK_W(64), .DIG_W(32)) dut (
    .clk(clk), .rst(rst), .init_i(init), .load_i(load), .fetch_i(fetch), .idata_i(idata),
    .ack_o(ack), .odata_o(odata), .err_o(err), .core_init_o(core_init),
    .core_start_o(core_start), .core_blk_o(core_blk), .core_done_i(core_done),
    .core_dig_i(core_dig)
`ifdef HASH_IO_CYCLE_CNT_EN
    , .cycle_cnt_o(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: digest = hi ^ lo of the started block, done 10 cycles after start.
  int          cd_cnt;
  logic [63:0] stub_blk;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_cnt <= 0; core_done <= 1'b0; core_dig <= '0; stub_blk <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        cd_cnt   <= 10;
        stub_blk <= core_blk;
      end else if (cd_cnt > 0) begin
        cd_cnt <= cd_cnt - 1;
        if (cd_cnt == 1) begin
          core_done <= 1'b1;
          core_dig  <= stub_blk[63:32] ^ stub_blk[31:0];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_init();
    init = 1'b1; tick(); init = 1'b0;
    chk("init_ack", ack, 1);
    chk("init_core_init", core_init, 1);
    chk("init_err_clr", err, 0);
  endtask

  // Loads NB random words with load held; returns the expected block and its digest.
  task automatic load_block(output logic [63:0] blk, output logic [31:0] dig);
    logic [15:0] words[$];
    blk = '0;
    for (int i = 0; i < 4; i++) words.push_back(16'($urandom));
    foreach (words[i]) blk = (blk << 16) | 64'(words[i]);
    dig = blk[63:32] ^ blk[31:0];
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; idata = words[i]; tick();
      if (i == 0) t_first = cyc;
      chk("load_ack", ack, 1);
    end
    load = 1'b0;
    chk("core_start_pulse", core_start, 1);
    chk("core_blk", core_blk, blk);
    tick();
    chk("core_start_single", core_start, 0);
    chk("hash_no_ack", ack, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (core_done) break;
      tick();
    end
    chk("core_done_seen", core_done, 1);
    tick();
  endtask

  task automatic fetch_digest(input logic [31:0] dig);
    fetch = 1'b1; tick();
    chk("fetch0_ack", ack, 1);
    chk("fetch0_odata", odata, dig[31:16]);
    tick();
    t_last = cyc;
    chk("fetch1_ack", ack, 1);
    chk("fetch1_odata", odata, dig[15:0]);
    fetch = 1'b0; tick();
    chk("fetch_idle_ack", ack, 0);
    chk("odata_hold", odata, dig[15:0]);
  endtask

  logic [63:0] blk;
  logic [31:0] dig;

  initial begin
    rst = 1'b1; init = 1'b0; load = 1'b0; fetch = 1'b0; idata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_core_init", core_init, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_odata", odata, 0);
    chk("rst_core_blk", core_blk, 0);
    rst = 1'b0; tick();

    // Scenarios 1 and 2: one block, then fetch the two digest words.
    do_init();
    load_block(blk, dig);
    wait_done();
    fetch_digest(dig);
`ifdef HASH_IO_CYCLE_CNT_EN
    chk("cycle_cnt", cycle_cnt, 64'(t_last - t_first));
    repeat (3) tick();
    chk("cycle_cnt_frozen", cycle_cnt, 64'(t_last - t_first));
`endif
    chk("no_err_after_fetch", err, 0);
    load = 1'b1; tick(); load = 1'b0;
    chk("idle_load_err", err, 1);
    chk("idle_load_no_ack", ack, 0);

    // Scenario 3: a load held through HASH is accepted one cycle after core_done.
    do_init();
    load_block(blk, dig);
    load = 1'b1; idata = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("hash_backpressure", ack, 0);
      if (core_done) break;
    end
    chk("bp_core_done", core_done, 1);
    tick();
    chk("bp_done_edge_no_ack", ack, 0);
    tick();
    chk("bp_accept", ack, 1);
    load = 1'b0;

    // Scenario 4: protocol errors.
    load = 1'b1; fetch = 1'b1; tick(); load = 1'b0; fetch = 1'b0;
    chk("load_fetch_err", err, 1);
    chk("load_fetch_no_ack", ack, 0);
    do_init();
    fetch = 1'b1; tick(); fetch = 1'b0;
    chk("fetch_unhashed_err", err, 1);
    chk("fetch_unhashed_no_ack", ack, 0);
    do_init();
    for (int i = 0; i < 2; i++) begin
      load = 1'b1; idata = 16'($urandom); tick();
    end
    load = 1'b0;
    fetch = 1'b1; tick(); fetch = 1'b0;
    chk("fetch_wcnt_err", err, 1);
    chk("fetch_wcnt_no_ack", ack, 0);
    do_init();

    // Scenario 5: reset mid-block with ack and err both high.
    load = 1'b1; idata = 16'($urandom); tick();
    fetch = 1'b1; tick(); fetch = 1'b0;
    idata = 16'($urandom); tick(); load = 1'b0;
    chk("pre_rst_ack", ack, 1);
    chk("pre_rst_err", err, 1);
    rst = 1'b1; #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_odata", odata, 0);
    tick(); rst = 1'b0; tick();
    do_init();
    load_block(blk, dig);
    wait_done();
    fetch_digest(dig);

    // Random multi-block messages; only the last block's digest is read back.
    for (int m = 0; m < 3; m++) begin
      do_init();
      load_block(blk, dig);
      wait_done();
      load_block(blk, dig);
      wait_done();
      if (m == 2) begin
        fetch = 1'b1; tick(); fetch = 1'b0;
        chk("out_w0", odata, dig[31:16]);
        load = 1'b1; tick(); load = 1'b0;
        chk("out_load_err", err, 1);
        chk("out_load_no_ack", ack, 0);
        fetch = 1'b1; tick(); fetch = 1'b0;
        chk("out_w1_ack", ack, 1);
        chk("out_w1", odata, dig[15:0]);
      end else begin
        fetch_digest(dig);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
